// File: rtl/reg_file_sb_pkg.sv
// regfile_pkg: constants and helpers shared by the decode-stage register file
// and its scoreboard.
//   ZERO_REG / V0_REG / A0_REG / RA_REG : architectural register indices
//   port_lsb()                          : low bit of port k in a packed bus
package regfile_pkg;

    localparam int ZERO_REG = 0;
    localparam int V0_REG   = 2;
    localparam int A0_REG   = 4;
    localparam int RA_REG   = 31;

    // Packed multi-port buses place port k at [k*width +: width].
    function automatic int port_lsb(input int port, input int width);
        return port * width;
    endfunction

endpackage

// File: rtl/reg_file_sb_if.sv
// reg_file_sb_if: bundle of every non-clock/reset signal of the register file.
//   master : decode/issue/writeback side (drives ids, writes, issue, flush)
//   slave  : register file side (drives read data, busy flags, syscall taps)
interface reg_file_sb_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_READ   = 2
);
    logic [NUM_READ*ADDR_WIDTH-1:0] rd_id;
    logic [NUM_READ*DATA_WIDTH-1:0] rd_value;
    logic [NUM_READ-1:0]            rd_busy;

    logic                           wr_en;
    logic [ADDR_WIDTH-1:0]          wr_id;
    logic [DATA_WIDTH-1:0]          wr_value;

    logic                           link_wr;
    logic [DATA_WIDTH-1:0]          link_value;

    logic                           hilo_wr;
    logic [DATA_WIDTH-1:0]          hi_w;
    logic [DATA_WIDTH-1:0]          lo_w;
    logic [DATA_WIDTH-1:0]          hi_d;
    logic [DATA_WIDTH-1:0]          lo_d;
    logic                           hilo_busy;

    logic                           issue_valid;
    logic [ADDR_WIDTH-1:0]          issue_id;
    logic                           issue_hilo;
    logic                           flush;

    logic [DATA_WIDTH-1:0]          syscall_funct;
    logic [DATA_WIDTH-1:0]          syscall_param_1;

    modport master (
        output rd_id, wr_en, wr_id, wr_value, link_wr, link_value,
               hilo_wr, hi_w, lo_w, issue_valid, issue_id, issue_hilo, flush,
        input  rd_value, rd_busy, hi_d, lo_d, hilo_busy,
               syscall_funct, syscall_param_1
    );

    modport slave (
        input  rd_id, wr_en, wr_id, wr_value, link_wr, link_value,
               hilo_wr, hi_w, lo_w, issue_valid, issue_id, issue_hilo, flush,
        output rd_value, rd_busy, hi_d, lo_d, hilo_busy,
               syscall_funct, syscall_param_1
    );

endinterface

// File: rtl/reg_file_sb_scoreboard.sv
// reg_scoreboard: one pending-write bit per slot.
//   clock, reset_n : clock, async active-low reset
//   set_vec        : slots gaining a new producer this cycle
//   clr_vec        : slots whose producer writes back this cycle
//   flush          : squash, clears every slot and ignores set_vec
//   q_id           : packed query slot ids, NUM_QUERY x ID_WIDTH
//   q_busy         : per query, busy and not being cleared this cycle
// Slot 0 is the hardwired zero register and can never become busy.
module reg_scoreboard #(
    parameter int DEPTH     = 33,
    parameter int ID_WIDTH  = 6,
    parameter int NUM_QUERY = 3
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic [DEPTH-1:0]              set_vec,
    input  logic [DEPTH-1:0]              clr_vec,
    input  logic                          flush,
    input  logic [NUM_QUERY*ID_WIDTH-1:0] q_id,
    output logic [NUM_QUERY-1:0]          q_busy
);
    import regfile_pkg::*;

    localparam int SPACE = 2 ** ID_WIDTH;
    localparam logic [DEPTH-1:0] LIVE_MASK = {{(DEPTH-1){1'b1}}, 1'b0};

    logic [DEPTH-1:0] busy;
    logic [SPACE-1:0] busy_ext;
    logic [SPACE-1:0] clr_ext;

    // Set after clear so a younger producer issued in the same cycle as the
    // older one's writeback keeps the slot busy.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            busy <= '0;
        end else if (flush) begin
            busy <= '0;
        end else begin
            busy <= ((busy & ~clr_vec) | set_vec) & LIVE_MASK;
        end
    end

    // Widen to the full id space so any query id indexes in range.
    assign busy_ext = SPACE'(busy);
    assign clr_ext  = SPACE'(clr_vec);

    for (genvar k = 0; k < NUM_QUERY; k++) begin : gen_query
        localparam int LSB = port_lsb(k, ID_WIDTH);
        logic [ID_WIDTH-1:0] id;
        assign id        = q_id[LSB +: ID_WIDTH];
        assign q_busy[k] = busy_ext[id] & ~clr_ext[id];
    end

endmodule

// File: rtl/reg_file_sb.sv
// reg_file_sb: decode-stage register file with write-through bypass, link
// port, HI/LO and pending-write scoreboard.
//   clock, reset_n : clock, async active-low reset
//   bus (slave)    : read ports + busy, main/link/HI-LO writes, issue,
//                    flush, syscall taps (V0 / A0)
// Reads are combinational; an effective write in the current cycle is
// forwarded with link priority over the main port.
module reg_file_sb
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_READ   = 2,
    parameter int LINK_REG   = RA_REG
) (
    input  logic          clock,
    input  logic          reset_n,
    reg_file_sb_if.slave  bus
);

    localparam int DEPTH     = 2 ** ADDR_WIDTH;
    localparam int SB_DEPTH  = DEPTH + 1;
    localparam int SB_IDW    = ADDR_WIDTH + 1;
    localparam int NUM_LANES = NUM_READ + 2;

    localparam logic [ADDR_WIDTH-1:0] ZERO_ID   = ADDR_WIDTH'(ZERO_REG);
    localparam logic [ADDR_WIDTH-1:0] LINK_ID   = ADDR_WIDTH'(LINK_REG);
    localparam logic [SB_IDW-1:0]     HILO_SLOT = SB_IDW'(DEPTH);

    logic [DATA_WIDTH-1:0] bank [DEPTH];
    logic [DATA_WIDTH-1:0] hi_q;
    logic [DATA_WIDTH-1:0] lo_q;

    logic main_eff;
    logic link_eff;

    assign main_eff = bus.wr_en && (bus.wr_id != ZERO_ID);
    // Guarded so a link register mapped onto r0 still leaves r0 hardwired.
    assign link_eff = bus.link_wr && (LINK_ID != ZERO_ID);

    // Link write is applied last so it wins a collision on LINK_REG.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                bank[i] <= '0;
            end
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            if (main_eff) begin
                bank[bus.wr_id] <= bus.wr_value;
            end
            if (link_eff) begin
                bank[LINK_ID] <= bus.link_value;
            end
            if (bus.hilo_wr) begin
                hi_q <= bus.hi_w;
                lo_q <= bus.lo_w;
            end
        end
    end

    // Lanes 0..NUM_READ-1 serve the read ports; the last two are fixed taps
    // on V0 and A0 for the syscall unit and share the same bypass rule.
    for (genvar k = 0; k < NUM_LANES; k++) begin : gen_lane
        logic [ADDR_WIDTH-1:0] id;
        logic [DATA_WIDTH-1:0] val;

        if (k < NUM_READ) begin : g_port
            localparam int ID_LSB = port_lsb(k, ADDR_WIDTH);
            localparam int DV_LSB = port_lsb(k, DATA_WIDTH);
            assign id = bus.rd_id[ID_LSB +: ADDR_WIDTH];
            assign bus.rd_value[DV_LSB +: DATA_WIDTH] = val;
        end else if (k == NUM_READ) begin : g_v0
            assign id = ADDR_WIDTH'(V0_REG);
            assign bus.syscall_funct = val;
        end else begin : g_a0
            assign id = ADDR_WIDTH'(A0_REG);
            assign bus.syscall_param_1 = val;
        end

        always_comb begin
            if (id == ZERO_ID) begin
                val = '0;
            end else if (link_eff && (id == LINK_ID)) begin
                val = bus.link_value;
            end else if (main_eff && (id == bus.wr_id)) begin
                val = bus.wr_value;
            end else begin
                val = bank[id];
            end
        end
    end

    assign bus.hi_d = bus.hilo_wr ? bus.hi_w : hi_q;
    assign bus.lo_d = bus.hilo_wr ? bus.lo_w : lo_q;

    // Scoreboard slot map: 0..DEPTH-1 are registers, DEPTH is HI/LO.
    logic [SB_DEPTH-1:0]            set_vec;
    logic [SB_DEPTH-1:0]            clr_vec;
    logic [(NUM_READ+1)*SB_IDW-1:0] q_id;
    logic [NUM_READ:0]              q_busy;

    always_comb begin
        set_vec = '0;
        if (bus.issue_valid && (bus.issue_id != ZERO_ID)) begin
            set_vec[{1'b0, bus.issue_id}] = 1'b1;
        end
        set_vec[HILO_SLOT] = bus.issue_hilo;
    end

    always_comb begin
        clr_vec = '0;
        if (main_eff) begin
            clr_vec[{1'b0, bus.wr_id}] = 1'b1;
        end
        if (link_eff) begin
            clr_vec[{1'b0, LINK_ID}] = 1'b1;
        end
        clr_vec[HILO_SLOT] = bus.hilo_wr;
    end

    for (genvar k = 0; k < NUM_READ; k++) begin : gen_qid
        localparam int ID_LSB = port_lsb(k, ADDR_WIDTH);
        localparam int Q_LSB  = port_lsb(k, SB_IDW);
        assign q_id[Q_LSB +: SB_IDW] = {1'b0, bus.rd_id[ID_LSB +: ADDR_WIDTH]};
    end
    assign q_id[port_lsb(NUM_READ, SB_IDW) +: SB_IDW] = HILO_SLOT;

    reg_scoreboard #(
        .DEPTH     (SB_DEPTH),
        .ID_WIDTH  (SB_IDW),
        .NUM_QUERY (NUM_READ + 1)
    ) u_scoreboard (
        .clock   (clock),
        .reset_n (reset_n),
        .set_vec (set_vec),
        .clr_vec (clr_vec),
        .flush   (bus.flush),
        .q_id    (q_id),
        .q_busy  (q_busy)
    );

    assign bus.rd_busy   = q_busy[NUM_READ-1:0];
    assign bus.hilo_busy = q_busy[NUM_READ];

endmodule
